// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions: arbitration modes, channel FSM states and a
// width helper used to size channel-select fields.
package axis_pkg;

    localparam int ARB_SEL = 0;
    localparam int ARB_RR  = 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-stage valid/ready register slice; accepts a new word whenever the
// slot is empty or being drained in the same cycle.
module axis_reg_slice #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] data_reg;
    logic         valid_reg;

    assign in_ready  = !valid_reg || out_ready;
    assign out_data  = data_reg;
    assign out_valid = valid_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (in_ready) begin
            valid_reg <= in_valid;
            // Data is only captured on a real push so a stalled word never changes.
            if (in_valid) begin
                data_reg <= in_data;
            end
        end
    end

endmodule

// File: rtl/axis_mux_n1.sv
// N:1 AXI-Stream multiplexer: channel grant is locked for a whole frame,
// re-arbitrated in one IDLE cycle after each tlast, with a registered output.
module axis_mux_n1
    import axis_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 5,
    parameter int ARB_MODE = 0,
    localparam int SEL_W   = (clog2(NUM_CH) > 1) ? clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH*DATA_W-1:0] s_tdata,
    input  logic [NUM_CH-1:0]        s_tvalid,
    input  logic [NUM_CH-1:0]        s_tlast,
    output logic [NUM_CH-1:0]        s_tready,
    output logic [DATA_W-1:0]        m_tdata,
    output logic                     m_tvalid,
    output logic                     m_tlast,
    input  logic                     m_tready,
    output logic [SEL_W-1:0]         cur_ch,
    output logic                     busy,
    output logic [CNT_W-1:0]         frame_cnt
);

    state_t              state_reg;
    logic [SEL_W-1:0]    cur_ch_reg;
    logic [SEL_W-1:0]    rr_ptr_reg;
    logic [CNT_W-1:0]    frame_cnt_reg;

    logic [SEL_W-1:0]    sel_eff;
    logic [SEL_W-1:0]    winner;
    logic [SEL_W-1:0]    rr_next;
    logic                grant;
    logic                load;
    logic                push;
    logic                cur_valid;
    logic                cur_last;
    logic [DATA_W-1:0]   cur_data;
    logic [DATA_W:0]     m_word;
    logic [DATA_W-1:0]   ch_data [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_data[gi]  = s_tdata[gi*DATA_W +: DATA_W];
            assign s_tready[gi] = (cur_ch_reg == SEL_W'(gi)) && (state_reg == XFER) && load;
        end
    endgenerate

    assign sel_eff   = (NUM_CH == 1) ? '0 : sel;
    assign cur_data  = ch_data[cur_ch_reg];
    assign cur_valid = s_tvalid[cur_ch_reg];
    assign cur_last  = s_tlast[cur_ch_reg];
    assign push      = (state_reg == XFER) && cur_valid;

    // Grant candidate for the next frame; only consumed while in IDLE.
    always_comb begin
        logic [SEL_W:0] pos;
        logic [SEL_W:0] nxt;
        grant   = 1'b0;
        winner  = '0;
        rr_next = '0;
        pos     = '0;
        nxt     = '0;
        if (ARB_MODE == ARB_RR) begin
            for (int k = 0; k < NUM_CH; k++) begin
                pos = {1'b0, rr_ptr_reg} + (SEL_W+1)'(k);
                if (pos >= (SEL_W+1)'(NUM_CH)) begin
                    pos = pos - (SEL_W+1)'(NUM_CH);
                end
                if (!grant && s_tvalid[pos[SEL_W-1:0]]) begin
                    grant  = 1'b1;
                    winner = pos[SEL_W-1:0];
                end
            end
            nxt = {1'b0, winner} + 1'b1;
            if (nxt == (SEL_W+1)'(NUM_CH)) begin
                nxt = '0;
            end
            rr_next = nxt[SEL_W-1:0];
        end else begin
            if (({1'b0, sel_eff} < (SEL_W+1)'(NUM_CH)) && s_tvalid[sel_eff]) begin
                grant  = 1'b1;
                winner = sel_eff;
            end
        end
    end

    axis_reg_slice #(
        .W(DATA_W + 1)
    ) u_out_slice (
        .clk      (clk),
        .reset    (reset),
        .in_data  ({cur_last, cur_data}),
        .in_valid (push),
        .in_ready (load),
        .out_data (m_word),
        .out_valid(m_tvalid),
        .out_ready(m_tready)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cur_ch_reg    <= '0;
            rr_ptr_reg    <= '0;
            frame_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant) begin
                        state_reg  <= XFER;
                        cur_ch_reg <= winner;
                        if (ARB_MODE == ARB_RR) begin
                            rr_ptr_reg <= rr_next;
                        end
                    end
                end
                XFER: begin
                    // The tlast beat itself is still pushed into the slice this cycle.
                    if (push && load && cur_last) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
            if (m_tvalid && m_tready && m_tlast) begin
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
        end
    end

    assign m_tdata   = m_word[DATA_W-1:0];
    assign m_tlast   = m_word[DATA_W];
    assign cur_ch    = cur_ch_reg;
    assign busy      = (state_reg == XFER);
    assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_axis_mux_n1.sv
// Directed bench for axis_mux_n1: select mode, round-robin mode and a
// three-channel instance sharing one clock and reset.
module tb_axis_mux_n1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    // Select-mode instance, 4 channels
    logic [1:0]  a_sel;
    logic [31:0] a_tdata;
    logic [3:0]  a_tvalid, a_tlast, a_tready;
    logic [7:0]  a_mdata;
    logic        a_mvalid, a_mlast, a_mready;
    logic [1:0]  a_cur;
    logic        a_busy;
    logic [4:0]  a_cnt;

    // Round-robin instance, 4 channels
    logic [1:0]  r_sel;
    logic [31:0] r_tdata;
    logic [3:0]  r_tvalid, r_tlast, r_tready;
    logic [7:0]  r_mdata;
    logic        r_mvalid, r_mlast, r_mready;
    logic [1:0]  r_cur;
    logic        r_busy;
    logic [4:0]  r_cnt;

    // Select-mode instance, 3 channels
    logic [1:0]  c_sel;
    logic [23:0] c_tdata;
    logic [2:0]  c_tvalid, c_tlast, c_tready;
    logic [7:0]  c_mdata;
    logic        c_mvalid, c_mlast, c_mready;
    logic [1:0]  c_cur;
    logic        c_busy;
    logic [4:0]  c_cnt;

    axis_mux_n1 #(.DATA_W(8), .NUM_CH(4), .CNT_W(5), .ARB_MODE(0)) dut_sel (
        .clk(clk), .reset(reset), .sel(a_sel),
        .s_tdata(a_tdata), .s_tvalid(a_tvalid), .s_tlast(a_tlast), .s_tready(a_tready),
        .m_tdata(a_mdata), .m_tvalid(a_mvalid), .m_tlast(a_mlast), .m_tready(a_mready),
        .cur_ch(a_cur), .busy(a_busy), .frame_cnt(a_cnt)
    );

    axis_mux_n1 #(.DATA_W(8), .NUM_CH(4), .CNT_W(5), .ARB_MODE(1)) dut_rr (
        .clk(clk), .reset(reset), .sel(r_sel),
        .s_tdata(r_tdata), .s_tvalid(r_tvalid), .s_tlast(r_tlast), .s_tready(r_tready),
        .m_tdata(r_mdata), .m_tvalid(r_mvalid), .m_tlast(r_mlast), .m_tready(r_mready),
        .cur_ch(r_cur), .busy(r_busy), .frame_cnt(r_cnt)
    );

    axis_mux_n1 #(.DATA_W(8), .NUM_CH(3), .CNT_W(5), .ARB_MODE(0)) dut_c3 (
        .clk(clk), .reset(reset), .sel(c_sel),
        .s_tdata(c_tdata), .s_tvalid(c_tvalid), .s_tlast(c_tlast), .s_tready(c_tready),
        .m_tdata(c_mdata), .m_tvalid(c_mvalid), .m_tlast(c_mlast), .m_tready(c_mready),
        .cur_ch(c_cur), .busy(c_busy), .frame_cnt(c_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        a_sel = '0; a_tdata = '0; a_tvalid = '0; a_tlast = '0; a_mready = 1'b0;
        r_sel = '0; r_tdata = '0; r_tvalid = '0; r_tlast = '0; r_mready = 1'b0;
        c_sel = '0; c_tdata = '0; c_tvalid = '0; c_tlast = '0; c_mready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_eq("init_mvalid", a_mvalid, 0);
        check_eq("init_busy", a_busy, 0);
        check_eq("init_cnt", a_cnt, 0);
        check_eq("init_tready", a_tready, 0);

        // Reset in the middle of a ch1 frame
        a_sel = 2'd1; a_tvalid = 4'b0010; a_tdata[8 +: 8] = 8'hA1; a_mready = 1'b1;
        tick();
        check_eq("rst_grant_cur", a_cur, 1);
        check_eq("rst_grant_tready", a_tready, 4'b0010);
        tick();
        check_eq("rst_beat_data", a_mdata, 8'hA1);
        check_eq("rst_beat_valid", a_mvalid, 1);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        a_tvalid = '0;
        #1;
        check_eq("rst_mvalid", a_mvalid, 0);
        check_eq("rst_cnt", a_cnt, 0);
        check_eq("rst_tready", a_tready, 4'b0000);
        check_eq("rst_busy", a_busy, 0);
        check_eq("rst_cur", a_cur, 0);

        // sel=2 frame 22,33,44 with ch0 also pending; sel flips to 0 mid-frame
        a_sel = 2'd2;
        a_tdata[0 +: 8] = 8'h0A; a_tlast[0] = 1'b1;
        a_tdata[16 +: 8] = 8'h22; a_tlast[2] = 1'b0;
        a_tvalid = 4'b0101;
        tick();
        check_eq("sel_grant_cur", a_cur, 2);
        check_eq("sel_grant_busy", a_busy, 1);
        a_sel = 2'd0;
        tick();
        check_eq("sel_beat0", a_mdata, 8'h22);
        check_eq("sel_beat0_last", a_mlast, 0);
        check_eq("lock_cur0", a_cur, 2);
        a_tdata[16 +: 8] = 8'h33;
        tick();
        check_eq("sel_beat1", a_mdata, 8'h33);
        check_eq("lock_cur1", a_cur, 2);
        check_eq("lock_tready", a_tready, 4'b0100);
        a_tdata[16 +: 8] = 8'h44; a_tlast[2] = 1'b1;
        tick();
        check_eq("sel_beat2", a_mdata, 8'h44);
        check_eq("sel_beat2_last", a_mlast, 1);
        check_eq("sel_idle_busy", a_busy, 0);
        check_eq("sel_cnt_before", a_cnt, 0);
        a_tvalid = 4'b0001;
        tick();
        check_eq("sel_cnt_after", a_cnt, 1);
        check_eq("sel_next_cur", a_cur, 0);
        check_eq("sel_next_busy", a_busy, 1);
        check_eq("sel_gap_mvalid", a_mvalid, 0);
        tick();
        check_eq("ch0_beat", a_mdata, 8'h0A);
        check_eq("ch0_last", a_mlast, 1);
        a_tvalid = '0;
        tick();
        check_eq("ch0_cnt", a_cnt, 2);

        // Backpressure: 55 held for 5 stalled cycles, then 66, 77
        a_sel = 2'd2; a_tdata[16 +: 8] = 8'h55; a_tlast[2] = 1'b0; a_tvalid = 4'b0100;
        tick();
        tick();
        a_tdata[16 +: 8] = 8'h66;
        a_mready = 1'b0;
        #1;
        check_eq("bp_first", a_mdata, 8'h55);
        check_eq("bp_tready_drop", a_tready, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_hold_data", a_mdata, 8'h55);
            check_eq("bp_hold_valid", a_mvalid, 1);
            check_eq("bp_hold_tready", a_tready, 4'b0000);
        end
        a_mready = 1'b1;
        #1;
        check_eq("bp_release_tready", a_tready, 4'b0100);
        tick();
        check_eq("bp_next", a_mdata, 8'h66);
        check_eq("bp_next_valid", a_mvalid, 1);
        a_tdata[16 +: 8] = 8'h77; a_tlast[2] = 1'b1;
        tick();
        check_eq("bp_last", a_mdata, 8'h77);
        check_eq("bp_last_flag", a_mlast, 1);
        a_tvalid = '0;
        tick();
        check_eq("bp_cnt", a_cnt, 3);
        check_eq("bp_drained", a_mvalid, 0);

        // Round-robin with every channel offering 1-beat frames; 33 frames wrap the counter
        r_tdata  = {8'h13, 8'h12, 8'h11, 8'h10};
        r_tlast  = 4'hF;
        r_tvalid = 4'hF;
        r_mready = 1'b1;
        for (int k = 0; k < 33; k++) begin
            tick();
            check_eq("rr_grant", r_cur, k % 4);
            check_eq("rr_cnt", r_cnt, k % 32);
            tick();
            if (k < 5) begin
                check_eq("rr_data", r_mdata, 8'h10 + (k % 4));
                check_eq("rr_last", r_mlast, 1);
            end
        end
        tick();
        check_eq("rr_wrap_cnt", r_cnt, 1);

        // NUM_CH=3: sel=3 is out of range and must never grant
        c_tdata  = {8'hC2, 8'hC1, 8'hC0};
        c_tlast  = 3'b111;
        c_tvalid = 3'b111;
        c_mready = 1'b1;
        c_sel    = 2'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("c3_bad_busy", c_busy, 0);
            check_eq("c3_bad_tready", c_tready, 3'b000);
        end
        c_sel = 2'd1;
        tick();
        check_eq("c3_cur", c_cur, 1);
        check_eq("c3_tready", c_tready, 3'b010);
        tick();
        check_eq("c3_data", c_mdata, 8'hC1);
        check_eq("c3_valid", c_mvalid, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/axis_mux_n1.md
Name: axis_mux_n1

Overview:
- Parametrised N:1 AXI-Stream multiplexer with frame-locked channel arbitration and a registered output stage.
- Generalises the 2:1 AXI mux: width, channel count and arbitration mode are parameters; channel switches happen only on frame (tlast) boundaries.
- Includes a completed-frame counter.
- Sits between multiple stream producers and a single downstream consumer in the FPGA datapath.

Parameters:
- DATA_W, 8, tdata width per channel.
- NUM_CH, 4, number of slave channels (>=1).
- CNT_W, 5, width of frame_cnt.
- ARB_MODE, 0, 0 = software select via sel; 1 = round-robin.
- SEL_W (localparam), max(1, clog2(NUM_CH)), width of sel/cur_ch.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- sel  in  SEL_W  requested channel (ARB_MODE=0 only)
- s_tdata  in  NUM_CH*DATA_W  channel i at bits [i*DATA_W +: DATA_W]
- s_tvalid  in  NUM_CH  per-channel valid
- s_tlast  in  NUM_CH  per-channel end-of-frame
- s_tready  out  NUM_CH  per-channel ready
- m_tdata  out  DATA_W  output data, registered
- m_tvalid  out  1  output valid, registered
- m_tlast  out  1  output last, registered
- m_tready  in  1  downstream ready
- cur_ch  out  SEL_W  currently granted channel
- busy  out  1  high while in XFER
- frame_cnt  out  CNT_W  frames completed on master side, wraps

Behaviour:
- Reset (clk edge with reset=1): state=IDLE, m_tvalid=0, m_tlast=0, m_tdata=0, cur_ch=0, busy=0, frame_cnt=0, round-robin pointer=0, s_tready all 0. Reset mid-frame drops the in-flight beat and the frame remainder.
- Output stage: one register slice. load = !m_tvalid || m_tready.
- s_tready[cur_ch] = (state==XFER) && load. All other s_tready bits are 0. s_tready is 0 in IDLE.
- Slave handshake s_tvalid[cur_ch] && s_tready[cur_ch] copies tdata/tlast into the output register and sets m_tvalid=1 next cycle. Latency is 1 cycle.
- If load and no slave handshake: m_tvalid=0.
- While m_tvalid && !m_tready, m_tdata/m_tlast are held stable.
- Full throughput: one beat per cycle while both sides are ready.
- FSM IDLE:
  - ARB_MODE=0: if sel<NUM_CH and s_tvalid[sel], then cur_ch<=sel and go to XFER. If sel>=NUM_CH, stay in IDLE.
  - ARB_MODE=1: scan from (rr_ptr) upward with wrap; the first channel with s_tvalid set wins. On grant, cur_ch<=winner, rr_ptr<=winner+1 (mod NUM_CH), go to XFER.
  - No valid channel: stay in IDLE.
  - Arbitration costs exactly one IDLE cycle per frame.
- FSM XFER:
  - sel and other channels are ignored.
  - The slave handshake with s_tlast[cur_ch]=1 sends the FSM to IDLE next cycle. That beat is still registered normally.
  - A frame in progress is never interrupted.
- busy = (state==XFER).
- frame_cnt increments on m_tvalid && m_tready && m_tlast. It wraps from 2^CNT_W-1 to 0.
- A tlast beat held in the output register during IDLE/new grant is legal. The next frame's first beat enters only when load is true.
- NUM_CH=1: sel is ignored (treated as 0). Round-robin degenerates to always channel 0.
- Simultaneous master pop and slave push in the same cycle: new beat replaces the old one, m_tvalid stays 1.

Decomposition:
- Shared package axis_pkg:
  - ARB_SEL=0 and ARB_RR=1 constants.
  - State enum IDLE/XFER.
  - clog2 helper function.
- Natural sub-module: axis_reg_slice (DATA_W+1 wide, valid/ready, load rule above), reusable by other AXI blocks.
- Arbiter logic stays inline.

Test Plan:
- Reset check: reset high for 2 cycles mid-frame on ch1 -> next cycle m_tvalid=0, frame_cnt=0, s_tready=4'b0000, busy=0.
- ARB_MODE=0 basic: sel=2, ch2 sends 3 beats 8'h22, 8'h33, 8'h44 (last on 8'h44), m_tready=1 -> m_tdata shows 22, 33, 44 on consecutive cycles 1 cycle after acceptance; m_tlast=1 with 44; frame_cnt 0->1.
- Frame lock: sel toggles 2->0 during the ch2 frame -> cur_ch stays 2 until tlast accepted; ch0 is granted only after one IDLE cycle.
- Backpressure: m_tready=0 for 5 cycles mid-frame with data 8'h55 -> m_tdata holds 8'h55, s_tready[cur_ch]=0, no beat lost or duplicated; order resumes when m_tready=1.
- Round-robin: ARB_MODE=1, all 4 channels valid, 1-beat frames 8'h10, 8'h11, 8'h12, 8'h13 -> grant order 0,1,2,3,0; frame_cnt counts 1..5.
- Wrap / invalid select: CNT_W=5 with 33 frames -> frame_cnt reads 1 after the 33rd frame (wrapped past 31). sel=3 with NUM_CH=3 -> stays IDLE, no s_tready asserted.
